stoch_signed_matvec: RTL and testbench

STOCH_SIGNED_MATVEC -- requirements
Module: stoch_signed_matvec

---
 rtl/stoch_signed_matvec_pkg.sv | 22 ++
 rtl/stoch_signed_matvec_dot_prod.sv | 95 +++++++++
 rtl/stoch_signed_matvec.sv | 51 +++++
 tb/tb_stoch_signed_matvec.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/stoch_signed_matvec_pkg.sv
// Shared sizing helpers for the signed stochastic matrix-vector engine:
// popcount width and accumulator saturation bounds.
package stoch_signed_matvec_pkg;

    // Bits needed to hold a popcount in 0..2*vec_len
    function automatic int popcnt_w(input int vec_len);
        return $clog2(2 * vec_len + 1);
    endfunction

    function automatic int min_counter_size(input int vec_len);
        return popcnt_w(vec_len) + 2;
    endfunction

    function automatic int sat_max(input int counter_size);
        return (1 << (counter_size - 1)) - 1;
    endfunction

    function automatic int sat_min(input int counter_size);
        return -(1 << (counter_size - 1));
    endfunction

endpackage

// File: rtl/stoch_signed_matvec_dot_prod.sv
// One matrix row: signed product popcounts, residue accumulator with
// saturation, and the registered signed output bitstream pair.
module stoch_signed_dot_prod
    import stoch_signed_matvec_pkg::*;
#(
    parameter int VEC_LEN      = 4,
    parameter int COUNTER_SIZE = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               clr_i,
    input  logic [VEC_LEN-1:0] u_p_i,
    input  logic [VEC_LEN-1:0] u_n_i,
    input  logic [VEC_LEN-1:0] m_p_i,
    input  logic [VEC_LEN-1:0] m_n_i,
    output logic               y_p_o,
    output logic               y_n_o,
    output logic               sat_o
);
    localparam int PW = popcnt_w(VEC_LEN);
    // Two spare bits keep acc + pos - neg and the +/-1 step exact before clamping
    localparam int AW = COUNTER_SIZE + 2;
    localparam logic signed [AW-1:0] ACC_MAX = AW'(sat_max(COUNTER_SIZE));
    localparam logic signed [AW-1:0] ACC_MIN = AW'(sat_min(COUNTER_SIZE));

    logic [VEC_LEN-1:0]             pos_bits, neg_bits;
    logic [PW-1:0]                  pos_cnt, neg_cnt;
    logic signed [AW-1:0]           sum, step;
    logic signed [COUNTER_SIZE-1:0] acc_q, acc_d;
    logic                           y_p_q, y_n_q, sat_q;
    logic                           y_p_d, y_n_d, clamp;

    assign pos_bits = (m_p_i & u_p_i) | (m_n_i & u_n_i);
    assign neg_bits = (m_p_i & u_n_i) | (m_n_i & u_p_i);

    always_comb begin
        pos_cnt = '0;
        neg_cnt = '0;
        for (int i = 0; i < VEC_LEN; i++) begin
            pos_cnt = pos_cnt + PW'(pos_bits[i]);
            neg_cnt = neg_cnt + PW'(neg_bits[i]);
        end
    end

    always_comb begin
        sum   = AW'(acc_q) + AW'($signed({1'b0, pos_cnt})) - AW'($signed({1'b0, neg_cnt}));
        y_p_d = 1'b0;
        y_n_d = 1'b0;
        step  = '0;
        if (!sum[AW-1] && (sum != '0)) begin
            y_p_d = 1'b1;
            step  = sum - AW'(1);
        end else if (sum[AW-1]) begin
            y_n_d = 1'b1;
            step  = sum + AW'(1);
        end
        clamp = 1'b1;
        if (step > ACC_MAX) begin
            acc_d = ACC_MAX[COUNTER_SIZE-1:0];
        end else if (step < ACC_MIN) begin
            acc_d = ACC_MIN[COUNTER_SIZE-1:0];
        end else begin
            acc_d = step[COUNTER_SIZE-1:0];
            clamp = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
            y_p_q <= 1'b0;
            y_n_q <= 1'b0;
            sat_q <= 1'b0;
        end else if (clr_i) begin
            acc_q <= '0;
            y_p_q <= 1'b0;
            y_n_q <= 1'b0;
            sat_q <= 1'b0;
        end else if (en_i) begin
            acc_q <= acc_d;
            y_p_q <= y_p_d;
            y_n_q <= y_n_d;
            sat_q <= sat_q | clamp;
        end else begin
            y_p_q <= 1'b0;
            y_n_q <= 1'b0;
        end
    end

    assign y_p_o = y_p_q;
    assign y_n_o = y_n_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/stoch_signed_matvec.sv
// Signed stochastic matrix-vector product: NUM_ROWS independent dot-product
// rows sharing one input vector bitstream pair.
module stoch_signed_matvec
    import stoch_signed_matvec_pkg::*;
#(
    parameter int VEC_LEN      = 4,
    parameter int NUM_ROWS     = 2,
    parameter int COUNTER_SIZE = 8
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         en,
    input  logic                         clr,
    input  logic [VEC_LEN-1:0]           u_p,
    input  logic [VEC_LEN-1:0]           u_n,
    input  logic [NUM_ROWS*VEC_LEN-1:0]  m_p,
    input  logic [NUM_ROWS*VEC_LEN-1:0]  m_n,
    output logic [NUM_ROWS-1:0]          y_p,
    output logic [NUM_ROWS-1:0]          y_n,
    output logic [NUM_ROWS-1:0]          sat
);
    if (VEC_LEN < 2) begin : g_bad_vec_len
        $error("VEC_LEN must be >= 2");
    end
    if (NUM_ROWS < 1) begin : g_bad_num_rows
        $error("NUM_ROWS must be >= 1");
    end
    if (COUNTER_SIZE < min_counter_size(VEC_LEN)) begin : g_bad_counter_size
        $error("COUNTER_SIZE too small for VEC_LEN");
    end

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        stoch_signed_dot_prod #(
            .VEC_LEN      (VEC_LEN),
            .COUNTER_SIZE (COUNTER_SIZE)
        ) u_row (
            .clk_i (CLK),
            .rst_i (RST),
            .en_i  (en),
            .clr_i (clr),
            .u_p_i (u_p),
            .u_n_i (u_n),
            .m_p_i (m_p[r*VEC_LEN +: VEC_LEN]),
            .m_n_i (m_n[r*VEC_LEN +: VEC_LEN]),
            .y_p_o (y_p[r]),
            .y_n_o (y_n[r]),
            .sat_o (sat[r])
        );
    end

endmodule

// File: tb/tb_stoch_signed_matvec.sv
// Directed bench for stoch_signed_matvec with an integer reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_stoch_signed_matvec;
    localparam int VL = 4;
    localparam int NR = 2;
    localparam int CS = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          en  = 1'b0;
    logic          clr = 1'b0;
    logic [VL-1:0] u_p = '0;
    logic [VL-1:0] u_n = '0;
    logic [NR*VL-1:0] m_p = '0;
    logic [NR*VL-1:0] m_n = '0;
    logic [NR-1:0] y_p, y_n, sat;

    int errors = 0;
    int checks = 0;
    bit run_chk = 1'b0;

    int mdl_acc [NR];
    int mdl_yp  [NR];
    int mdl_yn  [NR];
    int mdl_sat [NR];

    stoch_signed_matvec #(.VEC_LEN(VL), .NUM_ROWS(NR), .COUNTER_SIZE(CS)) dut (
        .CLK(CLK), .RST(RST), .en(en), .clr(clr),
        .u_p(u_p), .u_n(u_n), .m_p(m_p), .m_n(m_n),
        .y_p(y_p), .y_n(y_n), .sat(sat)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int acc_of(input int r);
        if (r == 0) return int'(dut.g_row[0].u_row.acc_q);
        return int'(dut.g_row[1].u_row.acc_q);
    endfunction

    // Reference model: signed counts and integer residue, straight from the rules
    always @(posedge CLK or posedge RST) begin
        if (RST || clr) begin
            for (int r = 0; r < NR; r++) begin
                mdl_acc[r] = 0; mdl_yp[r] = 0; mdl_yn[r] = 0; mdl_sat[r] = 0;
            end
        end else if (!en) begin
            for (int r = 0; r < NR; r++) begin
                mdl_yp[r] = 0; mdl_yn[r] = 0;
            end
        end else begin
            for (int r = 0; r < NR; r++) begin
                int pos, neg, nv, lo, hi;
                pos = 0; neg = 0;
                for (int i = 0; i < VL; i++) begin
                    pos += int'((m_p[r*VL+i] & u_p[i]) | (m_n[r*VL+i] & u_n[i]));
                    neg += int'((m_p[r*VL+i] & u_n[i]) | (m_n[r*VL+i] & u_p[i]));
                end
                nv = mdl_acc[r] + pos - neg;
                mdl_yp[r] = (nv >= 1) ? 1 : 0;
                mdl_yn[r] = (nv <= -1) ? 1 : 0;
                if (nv >= 1) nv = nv - 1;
                else if (nv <= -1) nv = nv + 1;
                lo = -(1 << (CS - 1));
                hi = (1 << (CS - 1)) - 1;
                if (nv > hi) begin nv = hi; mdl_sat[r] = 1; end
                if (nv < lo) begin nv = lo; mdl_sat[r] = 1; end
                mdl_acc[r] = nv;
            end
        end
    end

    always @(negedge CLK) begin
        if (run_chk) begin
            for (int r = 0; r < NR; r++) begin
                chk($sformatf("model_y_p[%0d]", r), int'(y_p[r]), mdl_yp[r]);
                chk($sformatf("model_y_n[%0d]", r), int'(y_n[r]), mdl_yn[r]);
                chk($sformatf("model_sat[%0d]", r), int'(sat[r]), mdl_sat[r]);
                chk($sformatf("model_acc[%0d]", r), acc_of(r), mdl_acc[r]);
            end
        end
    end

    task automatic step(input logic e, input logic c, input logic [VL-1:0] up, input logic [VL-1:0] un,
                        input logic [NR*VL-1:0] mp, input logic [NR*VL-1:0] mn);
        en = e; clr = c; u_p = up; u_n = un; m_p = mp; m_n = mn;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        // Reset state
        @(posedge CLK);
        @(negedge CLK);
        chk("reset_y_p", int'(y_p), 0);
        chk("reset_y_n", int'(y_n), 0);
        chk("reset_sat", int'(sat), 0);
        chk("reset_acc0", acc_of(0), 0);
        RST = 1'b0;
        run_chk = 1'b1;

        // pos=2 on row0 -> y_p every cycle, residue 1,2,3,4
        for (int k = 1; k <= 4; k++) begin
            step(1, 0, 4'b0011, 4'b0000, 8'h0F, 8'h00);
            chk("incr_y_p0", int'(y_p[0]), 1);
            chk("incr_acc0", acc_of(0), k);
        end
        chk("incr_row1_y_p", int'(y_p[1]), 0);

        // Single negative product from zero
        step(1, 1, '0, '0, '0, '0);
        step(1, 0, 4'b0000, 4'b0001, 8'h01, 8'h00);
        chk("neg_y_n0", int'(y_n[0]), 1);
        chk("neg_y_p0", int'(y_p[0]), 0);
        chk("neg_acc0", acc_of(0), 0);

        // Balanced row0 (pos=2, neg=2); row1 sees neg=2 and drifts negative
        step(1, 1, '0, '0, '0, '0);
        for (int k = 1; k <= 10; k++) begin
            step(1, 0, 4'b0011, 4'b1100, 8'h0F, 8'h30);
            chk("bal_y_p0", int'(y_p[0]), 0);
            chk("bal_y_n0", int'(y_n[0]), 0);
            chk("bal_acc0", acc_of(0), 0);
        end
        chk("bal_row1_y_n", int'(y_n[1]), 1);
        chk("bal_row1_acc", acc_of(1), -10);

        // Positive saturation: pos=4 grows residue by 3 per step, clamps on step 43
        step(1, 1, '0, '0, '0, '0);
        for (int k = 1; k <= 42; k++) step(1, 0, 4'b1111, 4'b0000, 8'h0F, 8'h00);
        chk("psat_acc0_pre", acc_of(0), 126);
        chk("psat_sat0_pre", int'(sat[0]), 0);
        step(1, 0, 4'b1111, 4'b0000, 8'h0F, 8'h00);
        chk("psat_acc0", acc_of(0), 127);
        chk("psat_sat0", int'(sat[0]), 1);
        for (int k = 1; k <= 3; k++) step(1, 0, '0, '0, '0, '0);
        chk("psat_sat0_sticky", int'(sat[0]), 1);
        chk("psat_acc0_drain", acc_of(0), 124);
        chk("psat_sat1", int'(sat[1]), 0);

        // Negative saturation: neg=4, clamps to -128 on step 43
        step(1, 1, '0, '0, '0, '0);
        for (int k = 1; k <= 43; k++) step(1, 0, 4'b0000, 4'b1111, 8'h0F, 8'h00);
        chk("nsat_acc0", acc_of(0), -128);
        chk("nsat_sat0", int'(sat[0]), 1);
        chk("nsat_y_n0", int'(y_n[0]), 1);

        // Hold with en=0, then clear overriding en
        step(1, 1, '0, '0, '0, '0);
        for (int k = 1; k <= 5; k++) step(1, 0, 4'b0011, 4'b0000, 8'h0F, 8'h00);
        for (int k = 1; k <= 3; k++) begin
            step(0, 0, 4'b0011, 4'b0000, 8'h0F, 8'h00);
            chk("hold_y_p0", int'(y_p[0]), 0);
            chk("hold_acc0", acc_of(0), 5);
        end
        step(1, 1, 4'b0011, 4'b0000, 8'h0F, 8'h00);
        chk("clr_acc0", acc_of(0), 0);
        chk("clr_y_p0", int'(y_p[0]), 0);
        chk("clr_sat", int'(sat), 0);

        // Asynchronous reset between edges discards residue
        for (int k = 1; k <= 6; k++) step(1, 0, 4'b0011, 4'b0000, 8'h0F, 8'h00);
        chk("pre_rst_acc0", acc_of(0), 6);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_y_p0", int'(y_p[0]), 0);
        chk("arst_acc0", acc_of(0), 0);
        @(negedge CLK);
        RST = 1'b0;
        step(1, 0, '0, '0, '0, '0);
        chk("post_rst_y_p", int'(y_p), 0);
        chk("post_rst_y_n", int'(y_n), 0);
        chk("post_rst_acc0", acc_of(0), 0);

        run_chk = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "bench timeout");
    end

endmodule
